tdm_dmux: RTL and testbench
===========================

# tdm_dmux

Time-division demultiplexer: the receiving end of a word-interleaved TDM link whose transmit side is built from Mux selection. It accepts a stream of WIDTH-bit words, one channel slot per accepted word, aligned by a frame marker. It collects one word per channel into a staging bank and publishes each complete frame atomically on a parallel output bus. It sits between the serial link input and the per-channel consumers in the datapath.

## Interface
- WIDTH, 16, bits per word/channel
- CHANNELS, 4, slots per frame; legal 2..8
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- in  in  WIDTH  incoming word
- in_valid  in  1  word present this cycle; accepted on every clock where high
- frame  in  1  qualifies in_valid; marks the word as slot 0 of a new frame
- out  out  WIDTH*CHANNELS  last complete frame; channel k at bits [k*WIDTH +: WIDTH]
- frame_done  out  1  one-cycle pulse: out updated this cycle
- chan_strobe  out  CHANNELS  one-hot pulse: slot k word written to staging
- slot  out  clog2(CHANNELS)  next slot index expected
- locked  out  1  1 in LOCK state
- sync_err  out  1  one-cycle pulse on misaligned frame marker

## Operation
- Single clock `clock`; reset is synchronous and active-high on `reset`.
- State machine: HUNT, LOCK.
  - HUNT: words with frame=0 are discarded (no strobe). Accepted word with frame=1 -> written to staging slot 0, slot<=1, state LOCK.
  - LOCK: accepted word with frame=0 -> written to staging[slot], slot increments. Accepted word with frame=1 at slot==0 -> normal frame start.
- Frame complete: the write to slot CHANNELS-1 wraps slot to 0. On the next edge, out <= whole staging bank including that word, and frame_done=1.
- Misaligned marker: frame=1 while LOCK and slot!=0. The partial frame is abandoned, with no frame_done and out unchanged. The word is written to slot 0 and slot<=1. sync_err pulses; see Configuration.
- in_valid=0: no state change; slot holds. Gaps between words are legal at any point.
- frame is ignored when in_valid=0.
- Reset values: out=0, frame_done=0, chan_strobe=0, slot=0, locked=0, sync_err=0, staging=0, state HUNT. Reset mid-frame discards the partial frame.
- Reset has priority over any simultaneous in_valid.

## Timing
- All outputs are registered.
- chan_strobe[k] is high in the cycle after the edge that accepts the slot-k word.
- Latency from the slot CHANNELS-1 accept edge to out/frame_done visible: 1 cycle.
- A frame of CHANNELS back-to-back words yields frame_done CHANNELS cycles after the first accept.
- Back-to-back frames are sustainable at full rate, with frame_done every CHANNELS cycles.
- Simultaneous wrap and new frame: a slot-0 word accepted on the same edge that publishes the previous frame is legal. Staging slot 0 is overwritten only after out has captured the old bank.
- locked rises one cycle after the first frame-marked accept and falls only on reset.

## Configuration
- TDM_DMUX_SYNC_CHECK_EN defined:
  - misaligned marker behaves as above;
  - sync_err pulses for one cycle, coincident with chan_strobe[0].
- Not defined:
  - a misaligned marker still restarts at slot 0 and drops the partial frame;
  - sync_err is tied to 0;
  - mismatch-detection logic is omitted.

## Test plan
CHANNELS=4, WIDTH=16.
- Reset, then 4 back-to-back words 0x1111,0x2222,0x3333,0x4444 with frame on the first -> chan_strobe 0001,0010,0100,1000. One cycle after the last strobe: frame_done=1, out=0x4444_3333_2222_1111.
- After reset, 3 words with frame=0, then a framed frame -> first 3 words produce no strobe and locked=0. locked=1 after the framed word; out matches only the framed data.
- Words with in_valid gaps of 0-3 idle cycles between slots -> same out as the gapless case. frame_done occurs exactly once; slot holds during gaps.
- Framed 0xAAAA,0xBBBB, then framed 0xC000..0xC003 -> no frame_done for the A/B frame; out=0xC003_C002_C001_C000. With TDM_DMUX_SYNC_CHECK_EN, sync_err=1 exactly once. Without it, sync_err stays 0.
- reset asserted after 2 slots of a frame -> all outputs 0 next cycle, state HUNT. A subsequent full frame publishes correctly.
- 3 continuous frames at full rate -> frame_done pulses 4 cycles apart, and each out equals its own frame's data.

Source files
------------

// File: rtl/tdm_dmux.sv
// tdm_dmux: receive side of a word-interleaved TDM link.
// Collects one word per channel slot into a staging bank, aligned by a frame
// marker, and publishes each complete frame atomically on a parallel bus.
// Optional build macro: TDM_DMUX_SYNC_CHECK_EN enables the misaligned-marker
// pulse on sync_err. When it is undefined, sync_err is tied low.
module tdm_dmux #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [WIDTH-1:0]            in,
  input  logic                        in_valid,
  input  logic                        frame,
  output logic [WIDTH*CHANNELS-1:0]   out,
  output logic                        frame_done,
  output logic [CHANNELS-1:0]         chan_strobe,
  output logic [$clog2(CHANNELS)-1:0] slot,
  output logic                        locked,
  output logic                        sync_err
);

  localparam int SLOT_W = $clog2(CHANNELS);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(CHANNELS - 1);

  localparam logic [0:0] HUNT = 1'b0;
  localparam logic [0:0] LOCK = 1'b1;

  logic [0:0]          state_reg, state_next;
  logic [SLOT_W-1:0]   slot_reg, slot_next;
  logic                publish_reg, publish_next;
  logic                frame_done_reg;
  logic [CHANNELS-1:0] chan_strobe_reg, chan_strobe_next;
  logic                wr_en;
  logic [SLOT_W-1:0]   wr_slot;

  // Decide which staging slot (if any) takes the incoming word and where
  // the slot counter goes next.
  always_comb begin
    state_next   = state_reg;
    slot_next    = slot_reg;
    publish_next = 1'b0;
    wr_en        = 1'b0;
    wr_slot      = '0;
    if (in_valid) begin
      if (frame) begin
        // A marker always restarts at slot 0, abandoning any partial frame.
        wr_en      = 1'b1;
        wr_slot    = '0;
        slot_next  = SLOT_W'(1);
        state_next = LOCK;
      end else if (state_reg == LOCK) begin
        wr_en   = 1'b1;
        wr_slot = slot_reg;
        if (slot_reg == LAST_SLOT) begin
          slot_next    = '0;
          publish_next = 1'b1;
        end else begin
          slot_next = slot_reg + SLOT_W'(1);
        end
      end
    end
    chan_strobe_next = wr_en ? (CHANNELS'(1) << wr_slot) : '0;
  end

  // Control state, slot counter and the one-cycle status pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg       <= HUNT;
      slot_reg        <= '0;
      publish_reg     <= 1'b0;
      frame_done_reg  <= 1'b0;
      chan_strobe_reg <= '0;
    end else begin
      state_reg       <= state_next;
      slot_reg        <= slot_next;
      publish_reg     <= publish_next;
      frame_done_reg  <= publish_reg;
      chan_strobe_reg <= chan_strobe_next;
    end
  end

  // Per-channel staging word and published output word. The published copy
  // samples the staging bank one edge after the last slot is written, so a
  // slot-0 word arriving on that same edge cannot corrupt the old frame.
  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : gen_slot
      logic [WIDTH-1:0] stage_reg;
      logic [WIDTH-1:0] out_word_reg;

      // Staging write for this channel slot.
      always_ff @(posedge clock) begin
        if (reset) begin
          stage_reg <= '0;
        end else if (wr_en && (wr_slot == SLOT_W'(gi))) begin
          stage_reg <= in;
        end
      end

      // Atomic publish of this channel's word when a frame completes.
      always_ff @(posedge clock) begin
        if (reset) begin
          out_word_reg <= '0;
        end else if (publish_reg) begin
          out_word_reg <= stage_reg;
        end
      end

      assign out[gi*WIDTH +: WIDTH] = out_word_reg;
    end
  endgenerate

`ifdef TDM_DMUX_SYNC_CHECK_EN
  logic sync_err_reg;
  logic misalign;

  assign misalign = in_valid && frame && (state_reg == LOCK) && (slot_reg != '0);

  // Flag a marker that arrives mid-frame; lands with chan_strobe[0].
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_err_reg <= 1'b0;
    end else begin
      sync_err_reg <= misalign;
    end
  end

  assign sync_err = sync_err_reg;
`else
  assign sync_err = 1'b0;
`endif

  assign frame_done  = frame_done_reg;
  assign chan_strobe = chan_strobe_reg;
  assign slot        = slot_reg;
  assign locked      = (state_reg == LOCK);

endmodule

// File: tb/tb_tdm_dmux.sv
// Testbench for tdm_dmux (WIDTH=16, CHANNELS=4). A frame-level reference
// model tracks the words of the frame being assembled and the last
// published frame; every driven cycle is compared against it.
module tb_tdm_dmux;

  localparam int W  = 16;
  localparam int CH = 4;
  localparam int SW = $clog2(CH);
  localparam int VW = 1 + CH + SW + 1 + 1 + W*CH;
`ifdef TDM_DMUX_SYNC_CHECK_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  logic            clock = 1'b0;
  logic            reset;
  logic [W-1:0]    din;
  logic            in_valid;
  logic            frame;
  logic [W*CH-1:0] dout;
  logic            frame_done;
  logic [CH-1:0]   chan_strobe;
  logic [SW-1:0]   slot;
  logic            locked;
  logic            sync_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model state
  bit            m_locked;
  logic [W-1:0]  m_words[$];
  bit            m_pend;
  logic [W*CH-1:0] m_pend_val;
  logic [W*CH-1:0] e_out;
  logic            e_done;
  logic [CH-1:0]   e_strobe;
  logic            e_err;

  tdm_dmux #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clock(clock), .reset(reset), .in(din), .in_valid(in_valid), .frame(frame),
    .out(dout), .frame_done(frame_done), .chan_strobe(chan_strobe), .slot(slot),
    .locked(locked), .sync_err(sync_err)
  );

  always #5 clock = ~clock;

  function automatic logic [VW-1:0] obs();
    return {frame_done, chan_strobe, slot, locked, sync_err, dout};
  endfunction

  function automatic logic [VW-1:0] expv();
    return {e_done, e_strobe, SW'(m_words.size()), m_locked, e_err, e_out};
  endfunction

  // Frame-level model: a marker starts a new word list; a full list becomes
  // the published frame one edge later.
  task automatic model_edge(input bit v, input bit f, input logic [W-1:0] d);
    e_done = 1'b0;
    if (m_pend) begin
      e_out  = m_pend_val;
      e_done = 1'b1;
      m_pend = 1'b0;
    end
    e_strobe = '0;
    e_err    = 1'b0;
    if (v) begin
      if (f) begin
        if (m_locked && m_words.size() != 0) e_err = SYNC;
        m_words.delete();
        m_words.push_back(d);
        m_locked = 1'b1;
        e_strobe = CH'(1);
      end else if (m_locked) begin
        e_strobe = CH'(1) << m_words.size();
        m_words.push_back(d);
        if (m_words.size() == CH) begin
          for (int k = 0; k < CH; k++) m_pend_val[k*W +: W] = m_words[k];
          m_pend = 1'b1;
          m_words.delete();
        end
      end
    end
  endtask

  task automatic drive(input bit v, input bit f, input logic [W-1:0] d);
    in_valid = v;
    frame    = f;
    din      = d;
    @(posedge clock);
    model_edge(v, f, d);
    cyc++;
    #1;
    in_valid = 1'b0;
    frame    = 1'($urandom);
    din      = W'($urandom);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'($urandom);
    frame    = 1'($urandom);
    din      = W'($urandom);
    @(posedge clock);
    m_locked = 1'b0; m_words.delete(); m_pend = 1'b0;
    e_out = '0; e_done = 1'b0; e_strobe = '0; e_err = 1'b0;
    cyc++;
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (obs() !== '0) begin
      bad++; $display("FAIL reset_state cyc=%0d got=%h want=0", cyc, obs());
    end
  endtask

  task automatic test_basic();
    logic [W-1:0] d [CH];
    d[0] = 16'h1111; d[1] = 16'h2222; d[2] = 16'h3333; d[3] = 16'h4444;
    for (int i = 0; i < CH; i++) begin
      drive(1'b1, i == 0, d[i]);
      total++;
      if (obs() !== expv() || chan_strobe !== CH'(1 << i)) begin
        bad++; $display("FAIL basic_slot%0d cyc=%0d got=%h want=%h", i, cyc, obs(), expv());
      end
    end
    drive(1'b0, 1'b0, 16'h0);
    total++;
    if (frame_done !== 1'b1 || dout !== 64'h4444_3333_2222_1111 || obs() !== expv()) begin
      bad++; $display("FAIL basic_publish cyc=%0d got=%h want=%h", cyc, obs(), expv());
    end
  endtask

  task automatic test_hunt();
    logic [W*CH-1:0] pk;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, W'($urandom));
      total++;
      if (obs() !== expv() || locked !== 1'b0 || chan_strobe !== '0) begin
        bad++; $display("FAIL hunt_discard cyc=%0d got=%h want=%h", cyc, obs(), expv());
      end
    end
    for (int i = 0; i < CH; i++) begin
      pk[i*W +: W] = W'($urandom);
      drive(1'b1, i == 0, pk[i*W +: W]);
      total++;
      if (obs() !== expv() || locked !== 1'b1) begin
        bad++; $display("FAIL hunt_lock cyc=%0d got=%h want=%h", cyc, obs(), expv());
      end
    end
    drive(1'b0, 1'b0, '0);
    total++;
    if (dout !== pk || frame_done !== 1'b1) begin
      bad++; $display("FAIL hunt_out cyc=%0d got=%h want=%h", cyc, dout, pk);
    end
  endtask

  task automatic test_gaps();
    logic [W*CH-1:0] pk;
    int done_cnt = 0;
    for (int i = 0; i < CH; i++) begin
      pk[i*W +: W] = W'($urandom);
      drive(1'b1, i == 0, pk[i*W +: W]);
      done_cnt += int'(frame_done);
      total++;
      if (obs() !== expv()) begin
        bad++; $display("FAIL gaps_word cyc=%0d got=%h want=%h", cyc, obs(), expv());
      end
      for (int g = 0; g < int'($urandom_range(3, 0)); g++) begin
        drive(1'b0, 1'($urandom), W'($urandom));
        done_cnt += int'(frame_done);
        total++;
        if (obs() !== expv()) begin
          bad++; $display("FAIL gaps_idle cyc=%0d got=%h want=%h", cyc, obs(), expv());
        end
      end
    end
    for (int g = 0; g < 2; g++) begin
      drive(1'b0, 1'b0, '0);
      done_cnt += int'(frame_done);
    end
    total++;
    if (done_cnt != 1 || dout !== pk) begin
      bad++; $display("FAIL gaps_result done=%0d want=1 out=%h want=%h", done_cnt, dout, pk);
    end
  endtask

  task automatic test_misalign();
    int done_cnt = 0;
    int err_cnt  = 0;
    drive(1'b1, 1'b1, 16'hAAAA);
    drive(1'b1, 1'b0, 16'hBBBB);
    for (int i = 0; i < CH; i++) begin
      drive(1'b1, i == 0, 16'hC000 + W'(i));
      done_cnt += int'(frame_done);
      err_cnt  += int'(sync_err);
      total++;
      if (obs() !== expv()) begin
        bad++; $display("FAIL misalign_step cyc=%0d got=%h want=%h", cyc, obs(), expv());
      end
    end
    drive(1'b0, 1'b0, '0);
    done_cnt += int'(frame_done);
    total++;
    if (done_cnt != 1 || err_cnt != int'(SYNC) || dout !== 64'hC003_C002_C001_C000) begin
      bad++; $display("FAIL misalign_result done=%0d err=%0d out=%h want done=1 err=%0d out=c003c002c001c000",
                      done_cnt, err_cnt, dout, int'(SYNC));
    end
  endtask

  task automatic test_reset_mid();
    logic [W*CH-1:0] pk;
    drive(1'b1, 1'b1, W'($urandom));
    drive(1'b1, 1'b0, W'($urandom));
    do_reset();
    total++;
    if (obs() !== '0) begin
      bad++; $display("FAIL reset_mid cyc=%0d got=%h want=0", cyc, obs());
    end
    for (int i = 0; i < CH; i++) begin
      pk[i*W +: W] = W'($urandom);
      drive(1'b1, i == 0, pk[i*W +: W]);
    end
    drive(1'b0, 1'b0, '0);
    total++;
    if (dout !== pk || frame_done !== 1'b1 || obs() !== expv()) begin
      bad++; $display("FAIL reset_mid_refill cyc=%0d got=%h want=%h", cyc, dout, pk);
    end
  endtask

  task automatic test_back_to_back();
    logic [W*CH-1:0] pk [3];
    int done_at[$];
    int nf = 0;
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < CH; i++) pk[f][i*W +: W] = W'($urandom);
    for (int n = 0; n < 3*CH + 2; n++) begin
      if (n < 3*CH) drive(1'b1, (n % CH) == 0, pk[n / CH][(n % CH)*W +: W]);
      else drive(1'b0, 1'b0, '0);
      total++;
      if (obs() !== expv()) begin
        bad++; $display("FAIL b2b_step cyc=%0d got=%h want=%h", cyc, obs(), expv());
      end
      if (frame_done === 1'b1) begin
        done_at.push_back(n);
        total++;
        if (nf > 2 || dout !== pk[nf > 2 ? 2 : nf]) begin
          bad++; $display("FAIL b2b_frame%0d got=%h want=%h", nf, dout, pk[nf > 2 ? 2 : nf]);
        end
        nf++;
      end
    end
    total++;
    if (done_at.size() != 3 || done_at[1] - done_at[0] != CH || done_at[2] - done_at[1] != CH) begin
      bad++; $display("FAIL b2b_spacing count=%0d want=3 spacing=%0d want=%0d", done_at.size(),
                      done_at.size() > 1 ? done_at[1] - done_at[0] : -1, CH);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      bit v = ($urandom_range(3, 0) != 0);
      bit f = ($urandom_range(3, 0) == 0);
      drive(v, f, W'($urandom));
      total++;
      if (obs() !== expv()) begin
        bad++; $display("FAIL random_step cyc=%0d got=%h want=%h", cyc, obs(), expv());
      end
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; frame = 1'b0; din = '0;
    test_reset();
    test_basic();
    test_hunt();
    test_gaps();
    test_misalign();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
